lcg_sequencer: RTL



---
 rtl/lcg_pkg.sv | 15 +
 rtl/lcg_sequencer_if.sv | 27 ++
 rtl/lcg_next.sv | 24 ++
 rtl/lcg_sequencer.sv | 94 +++++++++
 4 files changed

// File: rtl/lcg_pkg.sv
// Shared constants and FSM encoding for the LCG sequencer slice.
package lcg_pkg;

    localparam int unsigned LCG_WIDTH        = 8;
    localparam int unsigned LCG_MULT         = 13;
    localparam int unsigned LCG_INC          = 1;
    localparam int unsigned LCG_DEFAULT_SEED = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } lcg_state_e;

endpackage

// File: rtl/lcg_sequencer_if.sv
// Control inputs and valid/ready sample stream of the LCG sequencer.
interface lcg_sequencer_if import lcg_pkg::*; #(
    parameter int unsigned WIDTH = LCG_WIDTH
) ();

    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             start;
    logic             stop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] sample_count;
    logic             period_wrap;
    logic             busy;

    modport master (
        input  seed_load, seed_in, start, stop, out_ready,
        output out_valid, out_data, sample_count, period_wrap, busy
    );

    modport slave (
        output seed_load, seed_in, start, stop, out_ready,
        input  out_valid, out_data, sample_count, period_wrap, busy
    );

endinterface

// File: rtl/lcg_next.sv
// Combinational LCG step: (MULT*cur + INC) mod 2^WIDTH as a shift-add over the set bits of MULT.
module lcg_next import lcg_pkg::*; #(
    parameter int unsigned WIDTH = LCG_WIDTH,
    parameter int unsigned MULT  = LCG_MULT,
    parameter int unsigned INC   = LCG_INC
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] acc;

    // Only the low WIDTH bits of each partial product survive the modulus.
    always_comb begin
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (MULT[i]) begin
                acc = acc + (cur << i);
            end
        end
        nxt = acc + WIDTH'(INC);
    end

endmodule

// File: rtl/lcg_sequencer.sv
// Registered, loadable LCG state streamed over valid/ready with sample counting and period flag.
module lcg_sequencer import lcg_pkg::*; #(
    parameter int unsigned WIDTH        = LCG_WIDTH,
    parameter int unsigned MULT         = LCG_MULT,
    parameter int unsigned INC          = LCG_INC,
    parameter int unsigned DEFAULT_SEED = LCG_DEFAULT_SEED
) (
    input logic             clk,
    input logic             rst_n,
    lcg_sequencer_if.master bus
);

    lcg_state_e       fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] period_seed_q;
    logic [WIDTH-1:0] count_q;
    logic             valid_q;
    logic             wrap_q;
    logic [WIDTH-1:0] nxt;
    logic             hs;

    lcg_next #(
        .WIDTH (WIDTH),
        .MULT  (MULT),
        .INC   (INC)
    ) u_next (
        .cur (state_q),
        .nxt (nxt)
    );

    assign hs = valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            state_q       <= WIDTH'(DEFAULT_SEED);
            period_seed_q <= WIDTH'(DEFAULT_SEED);
            count_q       <= '0;
            valid_q       <= 1'b0;
            wrap_q        <= 1'b0;
        end else if (bus.seed_load) begin
            // Load overrides everything: pending sample dropped, coincident handshake not counted.
            fsm_q         <= IDLE;
            state_q       <= bus.seed_in;
            period_seed_q <= bus.seed_in;
            count_q       <= '0;
            valid_q       <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            wrap_q <= hs && (count_q == '1);
            if (hs) begin
                state_q <= nxt;
                count_q <= count_q + WIDTH'(1);
            end
            case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        fsm_q         <= RUN;
                        valid_q       <= 1'b1;
                        count_q       <= '0;
                        period_seed_q <= state_q;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        if (hs) begin
                            fsm_q   <= IDLE;
                            valid_q <= 1'b0;
                        end else begin
                            fsm_q <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (hs) begin
                        fsm_q   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_data     = state_q;
    assign bus.sample_count = count_q;
    assign bus.period_wrap  = wrap_q;
    assign bus.busy         = (fsm_q != IDLE);

endmodule
